// File: rtl/simple_sequence_pkg.sv
`default_nettype none
// ============================================================================
// Package     : simple_sequence_pkg
// Description : Shared definitions for the serial sequence generator and the
//               matching sequence detector: state encoding, default pattern
//               length and default pattern value.
// Revision    : 1.0 - initial release
// ============================================================================
package simple_sequence_pkg;

    // Default pattern length in bits; legal range is 2..16.
    localparam int unsigned PAT_LEN_DEFAULT = 5;

    // Pattern sent when pattern_sel=0. Transmitted MSB first.
    localparam logic [4:0] PAT_DEFAULT_VALUE = 5'b10110;

    // Width of the repetition counter and of the reps input.
    localparam int unsigned REP_W = 4;

    // Transmission state machine.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // True when the bit being transferred is the very last one of the burst:
    // bit 0 of the final repetition. A counter of 0 is treated as final too,
    // so the repetition counter can never wrap below zero.
    function automatic logic is_final_bit(input logic idx_is_zero,
                                          input logic [REP_W-1:0] rep_cnt);
        return idx_is_zero && (rep_cnt <= REP_W'(1));
    endfunction

endpackage : simple_sequence_pkg
`default_nettype wire

// File: rtl/simple_sequence_generator.sv
`default_nettype none
// ============================================================================
// Module      : simple_sequence_generator
// Description : Serialises a PAT_LEN-bit pattern MSB first, repeated reps
//               times back to back, over a valid/ready handshake. A one-cycle
//               done pulse follows the final accepted bit.
// Ports       : clk          - clock, all state changes on rising edge
//               reset        - synchronous active-high reset
//               start        - begin a transmission (honoured in IDLE only)
//               pattern_sel  - 0: PAT_DEFAULT, 1: pattern_i (sampled w/ start)
//               pattern_i    - custom pattern, MSB first (sampled w/ start)
//               reps         - repetition count 1..15 (0 = request ignored)
//               seq          - registered serial bit, 0 whenever valid=0
//               valid        - registered, seq is meaningful
//               ready        - downstream accepts bit when valid && ready
//               busy         - high in SEND and DONE
//               done         - one-cycle pulse after the final bit transfers
// Revision    : 1.0 - initial release
// ============================================================================
module simple_sequence_generator
    import simple_sequence_pkg::*;
#(
    parameter int unsigned        PAT_LEN     = PAT_LEN_DEFAULT,
    parameter logic [PAT_LEN-1:0] PAT_DEFAULT = PAT_LEN'(PAT_DEFAULT_VALUE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pattern_sel,
    input  logic [PAT_LEN-1:0] pattern_i,
    input  logic [REP_W-1:0]   reps,
    output logic               seq,
    output logic               valid,
    input  logic               ready,
    output logic               busy,
    output logic               done
);

    localparam int unsigned      IDX_W   = $clog2(PAT_LEN);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_LEN - 1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    seq_state_e         state_q, state_d;
    logic [PAT_LEN-1:0] pat_q,   pat_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [REP_W-1:0]   rep_q,   rep_d;
    logic               seq_q,   seq_d;
    logic               valid_q, valid_d;

    logic [PAT_LEN-1:0] w_pat_sel;
    logic [IDX_W-1:0]   w_idx_dec;
    logic               w_xfer;
    logic               w_last;

    // Pattern that would be latched if start is accepted this cycle.
    assign w_pat_sel = pattern_sel ? pattern_i : PAT_DEFAULT;

    // Index of the bit that follows the one currently on seq.
    assign w_idx_dec = idx_q - IDX_W'(1);

    // A bit leaves the generator only when both sides agree.
    assign w_xfer = valid_q && ready;

    assign w_last = is_final_bit(idx_q == '0, rep_q);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        seq_d   = seq_q;
        valid_d = valid_q;

        unique case (state_q)
            ST_IDLE: begin
                // reps=0 is a null request: nothing to send, so stay put and
                // never produce a done pulse for it.
                if (start && (reps != '0)) begin
                    state_d = ST_SEND;
                    pat_d   = w_pat_sel;
                    idx_d   = IDX_MSB;
                    rep_d   = reps;
                    // Present the first bit straight away so valid rises in
                    // the cycle right after acceptance.
                    seq_d   = w_pat_sel[PAT_LEN-1];
                    valid_d = 1'b1;
                end
            end

            ST_SEND: begin
                // Without a transfer every register holds, which keeps seq
                // and valid stable under backpressure.
                if (w_xfer) begin
                    if (w_last) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                        rep_d   = '0;
                        seq_d   = 1'b0;
                        valid_d = 1'b0;
                    end else if (idx_q == '0) begin
                        // Wrap into the next repetition with no idle gap.
                        idx_d   = IDX_MSB;
                        rep_d   = rep_q - REP_W'(1);
                        seq_d   = pat_q[PAT_LEN-1];
                    end else begin
                        idx_d   = w_idx_dec;
                        seq_d   = pat_q[w_idx_dec];
                    end
                end
            end

            ST_DONE: begin
                // Single cycle; start is deliberately not looked at here.
                state_d = ST_IDLE;
                seq_d   = 1'b0;
                valid_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                seq_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            seq_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            seq_q   <= seq_d;
            valid_q <= valid_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign seq   = seq_q;
    assign valid = valid_q;
    // DONE lasts exactly one cycle, so decoding it gives a clean pulse.
    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);

endmodule : simple_sequence_generator
`default_nettype wire

// File: tb/tb_simple_sequence_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_simple_sequence_generator
// Description : Self-checking bench for simple_sequence_generator. Expected
//               bits are queued when a transmission is started and popped as
//               the generator hands bits over; a small reference detector
//               checks the looped-back stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simple_sequence_generator;

    localparam int unsigned PAT_LEN  = 5;
    localparam logic [4:0]  PAT_DEF  = 5'b10110;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       pattern_sel;
    logic [4:0] pattern_i;
    logic [3:0] reps;
    logic       seq;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    logic exp_q[$];   // scoreboard of bits still to be transferred
    logic rx_q[$];    // bits actually accepted, in order

    always #5 clk = ~clk;

    simple_sequence_generator #(
        .PAT_LEN     (PAT_LEN),
        .PAT_DEFAULT (PAT_DEF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pattern_sel (pattern_sel),
        .pattern_i   (pattern_i),
        .reps        (reps),
        .seq         (seq),
        .valid       (valid),
        .ready       (ready),
        .busy        (busy),
        .done        (done)
    );

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive start for one edge and queue the bits the transmission must carry.
    // Afterwards the inputs are scrambled: the latched copy must be used.
    task automatic start_tx(input logic sel, input logic [4:0] pat, input logic [3:0] n);
        logic [4:0] eff;
        eff         = sel ? pat : PAT_DEF;
        start       = 1'b1;
        pattern_sel = sel;
        pattern_i   = pat;
        reps        = n;
        for (int r = 0; r < int'(n); r++)
            for (int i = PAT_LEN - 1; i >= 0; i--)
                exp_q.push_back(eff[i]);
        tick();
        start       = 1'b0;
        pattern_sel = ~sel;
        pattern_i   = 5'($urandom);
        reps        = 4'($urandom);
    endtask

    // Run a transmission from the first cycle after acceptance (c=1).
    // ready is dropped for cycles [stall_from, stall_from+stall_len) and
    // start is re-pulsed at cycle poke_at. Returns once the cycle after
    // the done pulse has been checked, or when the budget runs out.
    task automatic collect(input int budget, input int stall_from, input int stall_len,
                           input int poke_at, output int n_bits, output int done_cnt,
                           output int done_cyc, output int gaps);
        n_bits   = 0;
        done_cnt = 0;
        done_cyc = -1;
        gaps     = 0;
        for (int c = 1; c <= budget; c++) begin
            if (done_cyc > 0 && c == done_cyc + 1) begin
                chk("busy_after_done", busy, 0);
                chk("done_one_cycle", done, 0);
                break;
            end
            ready = !(c >= stall_from && c < stall_from + stall_len);
            start = (c == poke_at);
            if (start) begin
                pattern_sel = 1'b1;
                pattern_i   = 5'b11111;
                reps        = 4'd15;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
                chk("done_busy", busy, 1);
            end
            if (valid) begin
                chk("busy_in_send", busy, 1);
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("seq_bit", seq, exp_q[0]);
                    if (ready) begin
                        rx_q.push_back(seq);
                        void'(exp_q.pop_front());
                        n_bits++;
                    end
                end
            end else begin
                chk("seq_zero_when_idle", seq, 0);
                if (done_cnt == 0) gaps++;
            end
            tick();
        end
        start = 1'b0;
        ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int nb, dc, dcyc, gp;
        int det_cnt;
        int det_pos[$];
        logic [4:0] sr;

        reset       = 1'b1;
        start       = 1'b0;
        pattern_sel = 1'b0;
        pattern_i   = '0;
        reps        = '0;
        ready       = 1'b1;

        // ---------------- reset state
        tick();
        tick();
        chk("rst_valid", valid, 0);
        chk("rst_seq", seq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        tick();

        // ---------------- default pattern, one repetition, ready always high
        start_tx(1'b0, 5'b00000, 4'd1);
        collect(20, 0, 0, 0, nb, dc, dcyc, gp);
        chk("a_bits", nb, 5);
        chk("a_done_cnt", dc, 1);
        chk("a_done_cycle", dcyc, 6);
        chk("a_gaps", gp, 0);
        chk("a_sb_empty", exp_q.size(), 0);

        // ---------------- backpressure while bit index 2 is shown
        start_tx(1'b0, 5'b00000, 4'd1);
        collect(30, 3, 3, 0, nb, dc, dcyc, gp);
        chk("b_bits", nb, 5);
        chk("b_done_cnt", dc, 1);
        chk("b_done_cycle", dcyc, 9);
        chk("b_sb_empty", exp_q.size(), 0);

        // ---------------- custom pattern, three reps, start poked mid-burst
        start_tx(1'b1, 5'b01001, 4'd3);
        collect(40, 0, 0, 4, nb, dc, dcyc, gp);
        chk("c_bits", nb, 15);
        chk("c_done_cnt", dc, 1);
        chk("c_done_cycle", dcyc, 16);
        chk("c_gaps", gp, 0);
        chk("c_sb_empty", exp_q.size(), 0);

        // ---------------- reps=0 request is ignored
        start       = 1'b1;
        pattern_sel = 1'b0;
        reps        = 4'd0;
        tick();
        start = 1'b0;
        chk("z_busy", busy, 0);
        chk("z_valid", valid, 0);
        tick();
        chk("z_busy2", busy, 0);
        chk("z_done", done, 0);

        // ---------------- reset while bit 3 is on the line
        start_tx(1'b0, 5'b00000, 4'd1);
        tick();
        chk("r_valid_before", valid, 1);
        chk("r_bit3", seq, PAT_DEF[3]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r_valid", valid, 0);
        chk("r_seq", seq, 0);
        chk("r_busy", busy, 0);
        chk("r_done", done, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("r_no_done", done, 0);
            chk("r_idle", busy, 0);
        end
        exp_q.delete();

        // ---------------- loopback into a reference detector
        rx_q.delete();
        start_tx(1'b0, 5'b00000, 4'd2);
        collect(30, 0, 0, 0, nb, dc, dcyc, gp);
        chk("l_bits", nb, 10);
        chk("l_done_cnt", dc, 1);
        det_cnt = 0;
        sr      = '0;
        foreach (rx_q[i]) begin
            sr = {sr[3:0], rx_q[i]};
            if (i >= 4 && sr == PAT_DEF) begin
                det_cnt++;
                det_pos.push_back(i + 1);
            end
        end
        chk("l_det_cnt", det_cnt, 2);
        chk("l_det_pos0", det_pos.size() > 0 ? det_pos[0] : -1, 5);
        chk("l_det_pos1", det_pos.size() > 1 ? det_pos[1] : -1, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_simple_sequence_generator
`default_nettype wire
